// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory request/ack port, the
// controller redirect port and the decode-side valid/ready port of the
// fetch stage. The master side is the fetch unit; the slave side is the
// surrounding memory/controller environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [1:0]  op;
  logic [3:0]  cond;
  logic [5:0]  funct;
  logic [3:0]  rd;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc, pc_plus8, op, cond, funct, rd
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc, pc_plus8, op, cond, funct, rd
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, requests words
// from instruction memory, buffers {word, pc} pairs in a DEPTH-entry FIFO
// and presents the head instruction plus pre-split decode fields to the
// controller. A redirect flushes everything and restarts fetch at the
// new (word-aligned) target.
// Optional feature: define FETCH_BYPASS_EN to let an ack into an empty
// FIFO appear on the instruction outputs in the same cycle.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          fifo_empty;
  logic          accept;
  logic          bypass_hit;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [31:0]   head_word;
  logic [31:0]   head_pc;
  logic [31:0]   redirect_target;

  assign fifo_empty      = (count == '0);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  // Memory request is held at the current fetch PC whenever there is room.
  always_comb begin
    bus.imem_req  = !reset && (count < FULL_COUNT);
    bus.imem_addr = fetch_pc;
  end

  // An ack only counts while we are requesting and no redirect discards it.
  assign accept = bus.imem_ack && bus.imem_req && !bus.redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = fifo_empty && accept;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never needs a FIFO slot.
  assign bypass_take = bypass_hit && bus.instr_ready;
  assign push        = accept && !bypass_take;
  assign pop         = !fifo_empty && bus.instr_ready && !bus.redirect;

  // Select the presented instruction: FIFO head, or the live memory word.
  always_comb begin
    bus.instr_valid = !fifo_empty;
    head_word       = word_mem[rd_ptr];
    head_pc         = pc_mem[rd_ptr];
    if (bypass_hit) begin
      bus.instr_valid = 1'b1;
      head_word       = bus.imem_rdata;
      head_pc         = fetch_pc;
    end
  end

  // Head fields and decode slices are pure functions of the head entry.
  always_comb begin
    bus.instr    = head_word;
    bus.instr_pc = head_pc;
    bus.pc_plus8 = head_pc + 32'd8;
    bus.op       = head_word[27:26];
    bus.cond     = head_word[31:28];
    bus.funct    = head_word[25:20];
    bus.rd       = head_word[15:12];
  end

  // Fetch PC, pointers and occupancy; redirect overrides push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (push)   wr_ptr   <= wr_ptr + 1'b1;
      if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as all zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      word_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule
